// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period and parity helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Clocks per bit, truncated; never below one so the baud counter stays valid.
    function automatic int calc_period(input int clk_freq, input int baud_rate);
        int p;
        p = clk_freq / baud_rate;
        return (p < 1) ? 1 : p;
    endfunction

    // Even parity of up to 9 data bits (zero-extended), inverted for odd sense.
    function automatic logic parity_bit(input logic [8:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high during the last clock of every PERIOD-cycle bit.
// clr holds the count at zero so the first bit of a frame starts fully aligned.
module uart_baud_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// Double-buffered UART transmitter, LSB first, start/data/[parity]/stop framing.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int PERIOD = calc_period(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W  = $clog2(DATA_BITS + 3);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    uart_state_t state_reg, state_next;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_empty_reg;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;
    logic                 par_reg, par_next;
    logic                 tick;
    logic                 baud_clr;
    logic                 load;
    logic                 accept;

    assign baud_clr = (state_reg == IDLE);

    uart_baud_gen #(
        .PERIOD(PERIOD)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    // Accept and load are mutually exclusive: load needs a full holding register.
    assign accept = data_valid && hold_empty_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            par_reg        <= 1'b0;
            hold_reg       <= '0;
            hold_empty_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            par_reg     <= par_next;
            if (accept) begin
                hold_reg       <= data;
                hold_empty_reg <= 1'b0;
            end else if (load) begin
                hold_empty_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        busy_next    = busy_reg;
        par_next     = par_reg;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                load      = !hold_empty_reg;
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = par_reg;
`else
                        state_next   = STOP;
                        tx_next      = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                tx_next = par_reg;
                if (tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        state_next   = IDLE;
                        tx_next      = 1'b1;
                        busy_next    = 1'b0;
                        bit_cnt_next = '0;
                        load         = !hold_empty_reg;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Loading overrides the above so back-to-back frames start with no idle cycle.
        if (load) begin
            state_next   = START;
            tx_next      = 1'b0;
            busy_next    = 1'b1;
            shift_next   = hold_reg;
            bit_cnt_next = '0;
            par_next     = parity_bit(9'(hold_reg), ODD);
        end
    end

    assign data_ready = hold_empty_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;

endmodule
